// File: rtl/csidh_ise_pkg.sv
// Shared constants and FSM state type for the CSIDH-512 reduced-radix (57-bit limb) RV64 ISE blocks.
package csidh_ise_pkg;

    localparam int unsigned XLEN    = 64;
    localparam int unsigned RADIX   = 57;
    localparam int unsigned DIGIT_W = 16;
    localparam int unsigned N       = XLEN / DIGIT_W;
    localparam int unsigned CNT_W   = (N > 1) ? $clog2(N) : 1;
    // Only product bits [RADIX+XLEN-1:0] can ever reach rd, so the accumulator stops there.
    localparam int unsigned ACC_W   = RADIX + XLEN;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MUL,
        ST_DONE
    } state_t;

endpackage

// File: rtl/csidh_madd57_dp.sv
// Digit-serial datapath: 64xDIGIT_W partial product, positional shift, accumulator, lu/hu select + rs3 add.
module csidh_madd57_dp
    import csidh_ise_pkg::*;
(
    input  logic             g_clk,
    input  logic             g_rst,
    input  logic             acc_clr_i,
    input  logic             acc_en_i,
    input  logic [CNT_W-1:0] cnt_i,
    input  logic [XLEN-1:0]  rs1_i,
    input  logic [XLEN-1:0]  rs2_i,
    input  logic [XLEN-1:0]  rs3_i,
    input  logic             op_lu_i,
    input  logic             op_hu_i,
    input  logic             res_en_i,
    output logic [XLEN-1:0]  rd_o
);

    logic [ACC_W-1:0]         acc_q, acc_d;
    logic [DIGIT_W-1:0]       digit;
    logic [XLEN+DIGIT_W-1:0]  pp;
    logic [ACC_W-1:0]         pp_sh;
    logic [31:0]              sh;
    logic [XLEN-1:0]          lu_sum, hu_sum;

    always_comb begin
        sh    = 32'(cnt_i) * DIGIT_W;
        digit = DIGIT_W'(rs2_i >> sh);
        pp    = {{DIGIT_W{1'b0}}, rs1_i} * {{XLEN{1'b0}}, digit};
        pp_sh = {{(ACC_W-XLEN-DIGIT_W){1'b0}}, pp} << sh;

        acc_d = acc_q;
        if (acc_clr_i) begin
            acc_d = '0;
        end else if (acc_en_i) begin
            acc_d = acc_q + pp_sh;
        end
    end

    always_ff @(posedge g_clk) begin
        if (g_rst) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    always_comb begin
        lu_sum = rs3_i + {{(XLEN-RADIX){1'b0}}, acc_q[RADIX-1:0]};
        hu_sum = rs3_i + acc_q[RADIX +: XLEN];
        rd_o   = '0;
        // Malformed op selects (both or neither) deliberately yield zero.
        if (res_en_i && op_lu_i && !op_hu_i) begin
            rd_o = lu_sum;
        end else if (res_en_i && op_hu_i && !op_lu_i) begin
            rd_o = hu_sum;
        end
    end

endmodule

// File: rtl/csidh_madd57_seq.sv
// madd57lu / madd57hu multiply-accumulate unit: FSM, step counter, operand capture and valid/ready handshake.
module csidh_madd57_seq
    import csidh_ise_pkg::*;
(
    input  logic            g_clk,
    input  logic            g_rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    input  logic [XLEN-1:0] rs3,
    input  logic            op_madd57lu,
    input  logic            op_madd57hu,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] rd
);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [XLEN-1:0]  rs1_q, rs1_d;
    logic [XLEN-1:0]  rs2_q, rs2_d;
    logic [XLEN-1:0]  rs3_q, rs3_d;
    logic             lu_q, lu_d;
    logic             hu_q, hu_d;
    logic             acc_clr, acc_en;

    always_ff @(posedge g_clk) begin
        if (g_rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            rs1_q   <= '0;
            rs2_q   <= '0;
            rs3_q   <= '0;
            lu_q    <= 1'b0;
            hu_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rs1_q   <= rs1_d;
            rs2_q   <= rs2_d;
            rs3_q   <= rs3_d;
            lu_q    <= lu_d;
            hu_q    <= hu_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rs1_d     = rs1_q;
        rs2_d     = rs2_q;
        rs3_d     = rs3_q;
        lu_d      = lu_q;
        hu_d      = hu_q;
        acc_clr   = 1'b0;
        acc_en    = 1'b0;
        in_ready  = 1'b0;
        out_valid = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    rs1_d   = rs1;
                    rs2_d   = rs2;
                    rs3_d   = rs3;
                    lu_d    = op_madd57lu;
                    hu_d    = op_madd57hu;
                    cnt_d   = '0;
                    acc_clr = 1'b1;
                    state_d = ST_MUL;
                end
            end
            ST_MUL: begin
                acc_en = 1'b1;
                if (cnt_q == CNT_W'(N - 1)) begin
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    csidh_madd57_dp u_dp (
        .g_clk     (g_clk),
        .g_rst     (g_rst),
        .acc_clr_i (acc_clr),
        .acc_en_i  (acc_en),
        .cnt_i     (cnt_q),
        .rs1_i     (rs1_q),
        .rs2_i     (rs2_q),
        .rs3_i     (rs3_q),
        .op_lu_i   (lu_q),
        .op_hu_i   (hu_q),
        .res_en_i  (state_q == ST_DONE),
        .rd_o      (rd)
    );

endmodule

// File: tb/tb_csidh_madd57_seq.sv
// Self-checking bench for csidh_madd57_seq: directed vector table, handshake corner cases, random ops vs 128-bit model.
module tb_csidh_madd57_seq;

    localparam int NSTEPS = 4;

    logic        g_clk = 1'b0;
    logic        g_rst;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] rs1, rs2, rs3;
    logic        op_madd57lu, op_madd57hu;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] rd;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] c;
        logic        lu;
        logic        hu;
        logic [63:0] exp;
    } vec_t;

    vec_t tbl[10];

    csidh_madd57_seq dut (
        .g_clk       (g_clk),
        .g_rst       (g_rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .rs1         (rs1),
        .rs2         (rs2),
        .rs3         (rs3),
        .op_madd57lu (op_madd57lu),
        .op_madd57hu (op_madd57hu),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .rd          (rd)
    );

    always #5 g_clk = ~g_clk;
    always @(posedge g_clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [63:0] model(input logic [63:0] a, input logic [63:0] b,
                                          input logic [63:0] c, input logic lu, input logic hu);
        logic [127:0] p;
        p = {64'd0, a} * {64'd0, b};
        if (lu && !hu) return c + {7'd0, p[56:0]};
        if (hu && !lu) return c + p[120:57];
        return 64'd0;
    endfunction

    function automatic logic [63:0] r64();
        return {$urandom, $urandom};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Present a request, wait for result, optionally stall out_ready for 'hold' cycles, then release.
    task automatic do_op(input logic [63:0] a, input logic [63:0] b, input logic [63:0] c,
                         input logic lu, input logic hu, input int hold, input string tag,
                         output logic [63:0] r, output int acc_cyc);
        int w;
        int lat;
        rs1 = a; rs2 = b; rs3 = c; op_madd57lu = lu; op_madd57hu = hu; in_valid = 1'b1;
        w = 0;
        while (!in_ready && w < 20) begin
            @(posedge g_clk); #1; w++;
        end
        chk({tag, " in_ready"}, {63'd0, in_ready}, 64'd1);
        @(posedge g_clk); #1;
        acc_cyc = cyc;
        in_valid = 1'b0;
        rs1 = r64(); rs2 = r64(); rs3 = r64();
        op_madd57lu = 1'($urandom); op_madd57hu = 1'($urandom);
        lat = 0;
        while (!out_valid && lat < 50) begin
            chk({tag, " busy in_ready"}, {63'd0, in_ready}, 64'd0);
            out_ready = 1'($urandom);
            in_valid = 1'($urandom);
            @(posedge g_clk); #1; lat++;
        end
        in_valid = 1'b0;
        chk({tag, " latency"}, 64'(lat), 64'(NSTEPS));
        r = rd;
        for (int i = 0; i < hold; i++) begin
            out_ready = 1'b0;
            in_valid = 1'($urandom);
            rs1 = r64(); rs2 = r64(); rs3 = r64();
            @(posedge g_clk); #1;
            chk({tag, " hold rd"}, rd, r);
            chk({tag, " hold out_valid"}, {63'd0, out_valid}, 64'd1);
            chk({tag, " hold in_ready"}, {63'd0, in_ready}, 64'd0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge g_clk); #1;
        out_ready = 1'b0;
        chk({tag, " after out_valid"}, {63'd0, out_valid}, 64'd0);
        chk({tag, " after rd"}, rd, 64'd0);
        chk({tag, " after in_ready"}, {63'd0, in_ready}, 64'd1);
    endtask

    initial begin
        logic [63:0] r, r2;
        int ca, cb;
        logic lu, hu;
        int sel;
        logic [63:0] a, b, c;

        tbl[0] = '{64'h01FF_FFFF_FFFF_FFFF, 64'h01FF_FFFF_FFFF_FFFF, 64'd0, 1'b1, 1'b0, 64'h1};
        tbl[1] = '{64'h01FF_FFFF_FFFF_FFFF, 64'h01FF_FFFF_FFFF_FFFF, 64'd0, 1'b0, 1'b1, 64'h01FF_FFFF_FFFF_FFFE};
        tbl[2] = '{64'd3, 64'd5, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 64'h0000_0000_0000_000E};
        tbl[3] = '{64'd3, 64'd5, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF};
        tbl[4] = '{64'd7, 64'd7, 64'd0, 1'b1, 1'b1, 64'd0};
        tbl[5] = '{64'd7, 64'd7, 64'd0, 1'b0, 1'b0, 64'd0};
        tbl[6] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1, 1'b0, 64'h1};
        tbl[7] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FF00};
        tbl[8] = '{64'h0100_0000_0000_0000, 64'd2, 64'd5, 1'b1, 1'b0, 64'd5};
        tbl[9] = '{64'h0100_0000_0000_0000, 64'd2, 64'd5, 1'b0, 1'b1, 64'd6};

        g_rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        rs1 = '0; rs2 = '0; rs3 = '0; op_madd57lu = 1'b0; op_madd57hu = 1'b0;
        repeat (2) @(posedge g_clk);
        #1 g_rst = 1'b0;
        chk("reset in_ready", {63'd0, in_ready}, 64'd1);
        chk("reset out_valid", {63'd0, out_valid}, 64'd0);
        chk("reset rd", rd, 64'd0);

        for (int i = 0; i < 10; i++) begin
            do_op(tbl[i].a, tbl[i].b, tbl[i].c, tbl[i].lu, tbl[i].hu, 0, $sformatf("vec%0d", i), r, ca);
            chk($sformatf("vec%0d rd", i), r, tbl[i].exp);
        end

        // backpressure for 10 cycles with stray in_valid pulses, then a fresh accept
        do_op(64'd1234567, 64'd7654321, 64'd99, 1'b1, 1'b0, 10, "bp", r, ca);
        chk("bp rd", r, model(64'd1234567, 64'd7654321, 64'd99, 1'b1, 1'b0));
        do_op(64'd3, 64'd5, 64'd1, 1'b1, 1'b0, 0, "bp next", r, ca);
        chk("bp next rd", r, 64'd16);

        // back-to-back throughput with out_ready released immediately
        do_op(64'd11, 64'd13, 64'd0, 1'b1, 1'b0, 0, "tp0", r, ca);
        do_op(64'd17, 64'd19, 64'd0, 1'b1, 1'b0, 0, "tp1", r2, cb);
        chk("throughput", 64'(cb - ca), 64'(NSTEPS + 2));
        chk("tp1 rd", r2, 64'd323);

        // reset during the second MUL cycle
        rs1 = 64'h01FF_FFFF_FFFF_FFFF; rs2 = 64'h01FF_FFFF_FFFF_FFFF; rs3 = 64'd0;
        op_madd57lu = 1'b0; op_madd57hu = 1'b1; in_valid = 1'b1;
        @(posedge g_clk); #1;
        in_valid = 1'b0;
        @(posedge g_clk); #1;
        g_rst = 1'b1;
        @(posedge g_clk); #1;
        g_rst = 1'b0;
        chk("rst mul out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst mul rd", rd, 64'd0);
        chk("rst mul in_ready", {63'd0, in_ready}, 64'd1);
        sel = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge g_clk); #1;
            if (out_valid) sel++;
        end
        chk("rst mul stale result", 64'(sel), 64'd0);
        do_op(64'd3, 64'd5, 64'd0, 1'b1, 1'b0, 0, "post rst", r, ca);
        chk("post rst rd", r, 64'd15);

        // reset while holding a result in DONE
        rs1 = 64'd9; rs2 = 64'd9; rs3 = 64'd0; op_madd57lu = 1'b1; op_madd57hu = 1'b0; in_valid = 1'b1;
        @(posedge g_clk); #1;
        in_valid = 1'b0; out_ready = 1'b0;
        repeat (NSTEPS + 2) @(posedge g_clk);
        #1;
        chk("pre rst done out_valid", {63'd0, out_valid}, 64'd1);
        chk("pre rst done rd", rd, 64'd81);
        g_rst = 1'b1;
        @(posedge g_clk); #1;
        g_rst = 1'b0;
        chk("rst done out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst done rd", rd, 64'd0);
        chk("rst done in_ready", {63'd0, in_ready}, 64'd1);

        // random ops, random stalls, random op encodings
        for (int i = 0; i < 100; i++) begin
            a = r64(); b = r64(); c = r64();
            if ($urandom_range(0, 3) == 0) begin
                a = a & 64'h01FF_FFFF_FFFF_FFFF;
                b = b & 64'h01FF_FFFF_FFFF_FFFF;
            end
            sel = int'($urandom_range(0, 9));
            lu = (sel == 0) || (sel >= 2 && sel < 6);
            hu = (sel == 0) || (sel >= 6);
            do_op(a, b, c, lu, hu, int'($urandom_range(0, 3)), $sformatf("rnd%0d", i), r, ca);
            chk($sformatf("rnd%0d rd", i), r, model(a, b, c, lu, hu));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
